// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small shift-register instruction buffer; entry 0 is always the head, so the
// head registers keep their last contents once the buffer drains.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [31:0]                  push_pc,
    input  logic [31:0]                  push_instr,
    input  logic                         pop,
    input  logic                         flush,
    output logic [31:0]                  head_pc,
    output logic [31:0]                  head_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    entries   [DEPTH];
    fetch_entry_t    entries_n [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_pop;
    logic [CW-1:0]   count_n;

    always_comb begin
        entries_n = entries;
        count_pop = count_q;
        // Only shift when something remains behind the head; a last pop leaves
        // entry 0 untouched so the outputs hold.
        if (pop && count_q != '0) begin
            if (count_q > CW'(1)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entries_n[i] = entries[i + 1];
                end
            end
            count_pop = count_q - CW'(1);
        end
        count_n = count_pop;
        if (push && count_pop < CW'(DEPTH)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_pop) begin
                    entries_n[i] = {push_pc, push_instr};
                end
            end
            count_n = count_pop + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            entries <= entries_n;
            count_q <= count_n;
        end
    end

    assign head_pc    = entries[0].pc;
    assign head_instr = entries[0].instr;
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, redirect handling and a
// small in-order instruction buffer.
//   state | meaning
//   FETCH | request fetch_pc whenever the buffer has room; acks push the buffer
//   DROP  | a redirected request is still in flight; hold it until ack, then discard
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int          CW       = $clog2(DEPTH + 1);
    localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] START_PC = RESET_PC & PC_MASK;

    fetch_state_t  state_q, state_n;
    logic [31:0]   fetch_pc_q, fetch_pc_n;
    logic [31:0]   drop_addr_q, drop_addr_n;
    logic [31:0]   target_pc;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    assign target_pc = redirect_pc & PC_MASK;
    assign pop       = instr_valid && instr_ready;

    always_comb begin
        state_n     = state_q;
        fetch_pc_n  = fetch_pc_q;
        drop_addr_n = drop_addr_q;
        mem_req     = 1'b0;
        mem_addr    = fetch_pc_q;
        push        = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req  = (count < CW'(DEPTH)) && !reset;
                mem_addr = fetch_pc_q;
                if (redirect) begin
                    fetch_pc_n = target_pc;
                    if (mem_req && !mem_ack) begin
                        state_n     = DROP;
                        drop_addr_n = fetch_pc_q;
                    end
                end else if (mem_req && mem_ack && !full) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc_q + 32'd4;
                end
            end
            DROP: begin
                // The memory still owns the old address; keep presenting it.
                mem_req  = !reset;
                mem_addr = drop_addr_q;
                if (redirect) begin
                    fetch_pc_n = target_pc;
                end
                if (mem_ack) begin
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            fetch_pc_q  <= START_PC;
            drop_addr_q <= START_PC;
        end else begin
            state_q     <= state_n;
            fetch_pc_q  <= fetch_pc_n;
            drop_addr_q <= drop_addr_n;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_pc    (fetch_pc_q),
        .push_instr (mem_rdata),
        .pop        (pop),
        .flush      (redirect),
        .head_pc    (instr_pc),
        .head_instr (instr),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    assign instr_valid = !empty;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning instruction-buffer entries (legal range 2..4).
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_req  output  1  instruction-memory request.
REQ-006 mem_addr  output  32  word-aligned fetch address, bits [1:0] always 00.
REQ-007 mem_ack  input  1  memory completes the transfer in any cycle where mem_req and mem_ack are both high.
REQ-008 mem_rdata  input  32  instruction word, valid only in an ack cycle.
REQ-009 redirect  input  1  branch/jump taken; flushes the block and restarts fetch.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored and treated as 00.
REQ-011 instr_valid  output  1  head buffer entry is valid.
REQ-012 instr  output  32  head instruction word.
REQ-013 instr_pc  output  32  address of the head instruction.
REQ-014 instr_ready  input  1  consumer (decoder/datapath) accepts the head entry when instr_valid is also high.

Function
REQ-015 At most one memory transaction SHALL be outstanding.
- mem_addr SHALL stay stable from mem_req rise until the ack cycle.
- mem_req SHALL not drop before ack, except on reset.
REQ-016 States:
- FETCH: mem_req = (buffer count < DEPTH) and not reset; mem_addr = fetch_pc.
- DROP: mem_req = 1, mem_addr = the address already in flight.
REQ-017 In FETCH, an ack without redirect SHALL:
- push {fetch_pc, mem_rdata} into the buffer;
- advance fetch_pc by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 A buffered instruction SHALL appear on instr/instr_pc with instr_valid high in the cycle after its ack cycle. Zero-wait memory gives 1 cycle of latency and 1 instruction per cycle throughput.
REQ-019 A pop SHALL occur when instr_valid and instr_ready are both high. Entries SHALL leave in push order.
REQ-020 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-021 When count == DEPTH, mem_req SHALL be low in FETCH. The buffer SHALL never overflow.
REQ-022 redirect SHALL take priority over push, pop and ack. On a redirect cycle:
- the buffer is flushed (instr_valid low next cycle);
- fetch_pc <= {redirect_pc[31:2], 2'b00};
- any pop that cycle is discarded.
REQ-023 Redirect next-state rules:
- redirect with a request pending and no ack that cycle SHALL move to DROP;
- redirect coinciding with an ack SHALL discard that data and stay in or return to FETCH;
- redirect with no request SHALL stay in FETCH.
REQ-024 DROP behaviour:
- the ack cycle SHALL discard mem_rdata and move to FETCH, issuing fetch_pc from the next cycle;
- a further redirect in DROP SHALL update fetch_pc and stay in DROP.
REQ-025 instr and instr_pc SHALL hold their last value when instr_valid is low. Only instr_valid is qualifying.
REQ-026 No output SHALL depend combinationally on mem_rdata. instr, instr_pc and instr_valid SHALL be driven from buffer registers.

Reset
REQ-027 While reset is high the block SHALL hold:
- mem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0;
- buffer empty, state FETCH, fetch_pc = RESET_PC.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction. The memory SHALL treat reset as cancelling the request.
REQ-029 The first mem_req SHALL rise in the first cycle after reset deasserts, with mem_addr = RESET_PC.

Structure
REQ-030 A shared package fetch_pkg SHALL hold:
- the state enumeration {FETCH, DROP};
- the buffer entry typedef {pc[31:0], instr[31:0]};
- the default RESET_PC constant.
REQ-031 The buffer SHALL be a sub-module fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, count, empty and full. Flush SHALL dominate push and pop.
REQ-032 fetch_unit SHALL contain the state machine, fetch_pc register and request logic only, about 150-300 lines total.

Verification
REQ-033 mem_ack tied 1, instr_ready tied 1, reset released -> mem_addr 0,4,8,... on consecutive cycles; instr_pc 0,4,8 with instr_valid high from the 2nd cycle after release.
REQ-034 instr_ready held 0 for 5 cycles, zero-wait memory -> exactly 2 pushes (pc 0,4), mem_req low thereafter; releasing ready pops pc 0 then 4, then fetch resumes at 8.
REQ-035 mem_ack delayed 3 cycles, redirect to 32'h0000_0043 in the 1st wait cycle -> mem_addr held until ack, that data never appears on instr, next mem_addr = 32'h0000_0040.
REQ-036 redirect to 32'h100 in the same cycle as an ack for pc 8, with 1 entry buffered -> instr_valid low next cycle; first delivered instr_pc = 32'h100.
REQ-037 redirect_pc = 32'hFFFF_FFFC, zero-wait memory -> delivered instr_pc FFFF_FFFC then 0000_0000.
REQ-038 reset asserted for 1 cycle while mem_req is high and unacked -> mem_req low that cycle, buffer empty, next mem_addr = RESET_PC.
